// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
//   fetch_entry_t : {addr, data} payload buffered between memory and decode
//   fetch_state_e : fetch control FSM states
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 8;
    localparam int unsigned ADDR_W      = 64;
    localparam int unsigned DATA_W      = 64;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fetch_entry_t;

    typedef enum logic {
        RESET_WAIT = 1'b0,
        RUN        = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO with synchronous flush.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : empty the FIFO next cycle (wins over push/pop)
//   push_i/data_i : write one entry
//   pop_i         : retire head entry (ignored when empty)
//   data_o        : head entry, valid whenever empty_o is low
//   empty_o, full_o, count_o : occupancy status
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type dtype = logic,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  dtype             data_i,
    input  logic             pop_i,
    output dtype             data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    dtype             mem_q [DEPTH];
    dtype             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop_en;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer/count update; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        pop_en   = pop_i && !empty_o;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_i, pop_en})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: issues sequential 8-byte fetches on the memory
// req/gnt/rvalid port, buffers in-order responses and presents {addr, data}
// to decode with valid/ready. A flush redirects and drops in-flight responses.
//   clk_i, rst_ni            : clock, async active-low reset
//   flush_i, flush_addr_i    : redirect to flush_addr_i (low 3 bits ignored)
//   instr_if_address_o/req_o/be_o, gnt_i, rvalid_i, rdata_i : memory port
//   fetch_valid_o, fetch_ready_i, fetch_addr_o, fetch_rdata_o : decode port
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] BOOT_ADDR       = 64'h0000_0000_0000_1000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic [63:0] flush_addr_i,
    output logic [63:0] instr_if_address_o,
    output logic        instr_if_data_req_o,
    output logic [3:0]  instr_if_data_be_o,
    input  logic        instr_if_data_gnt_i,
    input  logic        instr_if_data_rvalid_i,
    input  logic [63:0] instr_if_data_rdata_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [63:0] fetch_addr_o,
    output logic [63:0] fetch_rdata_o
);

    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W  = ((OUT_W > CNT_W) ? OUT_W : CNT_W) + 1;
    localparam logic [63:0] STEP   = 64'(INSTR_BYTES);
    localparam logic [63:0] BOOT_A = {BOOT_ADDR[63:3], 3'b000};

    fetch_state_e     state_q, state_d;
    logic [63:0]      npc_q, npc_d;
    logic [63:0]      rsp_addr_q, rsp_addr_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             req_c, fire_c, drop_rsp_c, push_c;
    logic [SUM_W-1:0] in_flight_c;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_empty, fifo_full;
    fetch_entry_t     push_entry, head_entry;
    logic             unused_flush_lsb;

    assign unused_flush_lsb = ^flush_addr_i[2:0];

    assign instr_if_address_o  = npc_q;
    assign instr_if_data_req_o = req_c;
    assign instr_if_data_be_o  = 4'hF;
    assign fetch_valid_o       = !fifo_empty;
    assign fetch_addr_o        = head_entry.addr;
    assign fetch_rdata_o       = head_entry.data;
    assign push_entry          = '{addr: rsp_addr_q, data: instr_if_data_rdata_i};

    // Request credit, response bookkeeping and redirect handling
    always_comb begin
        state_d     = state_q;
        npc_d       = npc_q;
        rsp_addr_d  = rsp_addr_q;
        outst_d     = outst_q;
        drop_cnt_d  = drop_cnt_q;

        if (state_q == RESET_WAIT) begin
            state_d = RUN;
        end

        // A request is only issued if its response is guaranteed a FIFO slot
        in_flight_c = SUM_W'(outst_q) + SUM_W'(fifo_cnt);
        req_c       = (state_q == RUN) && !flush_i
                      && (outst_q < OUT_W'(MAX_OUTSTANDING))
                      && (in_flight_c < SUM_W'(FIFO_DEPTH));
        fire_c      = req_c && instr_if_data_gnt_i;
        drop_rsp_c  = instr_if_data_rvalid_i && (drop_cnt_q != '0);
        push_c      = instr_if_data_rvalid_i && !drop_rsp_c && !flush_i;

        outst_d = outst_q + OUT_W'(fire_c) - OUT_W'(instr_if_data_rvalid_i);

        if (flush_i) begin
            npc_d      = {flush_addr_i[63:3], 3'b000};
            rsp_addr_d = {flush_addr_i[63:3], 3'b000};
            // Every response still owed belongs to the abandoned stream; a
            // response arriving this cycle is retired by the flush itself.
            drop_cnt_d = outst_q - OUT_W'(instr_if_data_rvalid_i);
        end else begin
            if (fire_c) begin
                npc_d = npc_q + STEP;
            end
            if (push_c) begin
                rsp_addr_d = rsp_addr_q + STEP;
            end
            if (drop_rsp_c) begin
                drop_cnt_d = drop_cnt_q - OUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RESET_WAIT;
            npc_q      <= BOOT_A;
            rsp_addr_q <= BOOT_A;
            outst_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            npc_q      <= npc_d;
            rsp_addr_q <= rsp_addr_d;
            outst_q    <= outst_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .dtype (fetch_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push_c),
        .data_i  (push_entry),
        .pop_i   (fetch_valid_o && fetch_ready_i),
        .data_o  (head_entry),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push_c |-> !fifo_full);
    a_rvalid_owed: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_if_data_rvalid_i |-> (outst_q != '0));
    a_outst_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outst_q <= OUT_W'(MAX_OUTSTANDING));
    a_drop_le_outst: assert property (@(posedge clk_i) disable iff (!rst_ni)
        drop_cnt_q <= outst_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table of stimulus and expected
// outputs driven against a small in-order memory model with fixed latency,
// plus a hand-written mid-operation reset sequence.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush;
    logic [63:0] flush_addr;
    logic [63:0] address;
    logic        req;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [63:0] rdata;
    logic        fvalid;
    logic        fready;
    logic [63:0] faddr;
    logic [63:0] frdata;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_ni),
        .flush_i                (flush),
        .flush_addr_i           (flush_addr),
        .instr_if_address_o     (address),
        .instr_if_data_req_o    (req),
        .instr_if_data_be_o     (be),
        .instr_if_data_gnt_i    (gnt),
        .instr_if_data_rvalid_i (rvalid),
        .instr_if_data_rdata_i  (rdata),
        .fetch_valid_o          (fvalid),
        .fetch_ready_i          (fready),
        .fetch_addr_o           (faddr),
        .fetch_rdata_o          (frdata)
    );

    typedef struct {
        bit          start;   // reset DUT and memory before this row
        int          lat;     // memory latency for the sequence started here
        bit          rdy;
        bit          g;
        bit          fl;
        logic [63:0] fa;
        bit          ereq;
        logic [63:0] eaddr;
        bit          evld;
        logic [63:0] efaddr;
    } vec_t;

    vec_t        vecs[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          lat    = 1;
    bit          sv[3];
    logic [63:0] sa[3];

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return a ^ 64'hC0DE_F00D_1234_5678;
    endfunction

    function automatic void add(input bit st, input int l, input bit rdy, input bit g,
                                input bit fl, input logic [63:0] fa, input bit ereq,
                                input logic [63:0] eaddr, input bit evld,
                                input logic [63:0] efaddr);
        vec_t v;
        v = '{st, l, rdy, g, fl, fa, ereq, eaddr, evld, efaddr};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Memory model: sample grant before the edge, answer lat cycles later
    task automatic adv();
        bit          fire;
        logic [63:0] a;
        fire = (req === 1'b1) && (gnt === 1'b1);
        a    = address;
        @(posedge clk);
        #1;
        sv[2] = sv[1]; sa[2] = sa[1];
        sv[1] = sv[0]; sa[1] = sa[0];
        sv[0] = fire;  sa[0] = a;
        rvalid = sv[lat-1];
        rdata  = sv[lat-1] ? mem_word(sa[lat-1]) : 64'h0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        rvalid = 1'b0; rdata = '0;
        sv = '{1'b0, 1'b0, 1'b0};
        fready = 1'b0; gnt = 1'b0; flush = 1'b0; flush_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst req", 64'(req), 64'd0);
        chk("rst addr", address, 64'h1000);
        chk("rst valid", 64'(fvalid), 64'd0);
        chk("rst be", 64'(be), 64'hF);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0; flush = 1'b0; flush_addr = '0; gnt = 1'b0;
        rvalid = 1'b0; rdata = '0; fready = 1'b0;

        // S1: streaming, single-cycle memory, always ready
        add(1,1,1,1,0,0, 0,64'h1000, 0,0);
        add(0,1,1,1,0,0, 1,64'h1000, 0,0);
        add(0,1,1,1,0,0, 1,64'h1008, 0,0);
        add(0,1,1,1,0,0, 1,64'h1010, 1,64'h1000);
        add(0,1,1,1,0,0, 1,64'h1018, 1,64'h1008);
        add(0,1,1,1,0,0, 1,64'h1020, 1,64'h1010);
        // S2: consumer stalls; exactly four requests, then drains losslessly
        add(1,1,0,1,0,0, 0,64'h1000, 0,0);
        add(0,1,0,1,0,0, 1,64'h1000, 0,0);
        add(0,1,0,1,0,0, 1,64'h1008, 0,0);
        add(0,1,0,1,0,0, 1,64'h1010, 1,64'h1000);
        add(0,1,0,1,0,0, 1,64'h1018, 1,64'h1000);
        add(0,1,0,1,0,0, 0,64'h1020, 1,64'h1000);
        for (int k = 0; k < 5; k++) add(0,1,0,1,0,0, 0,64'h1020, 1,64'h1000);
        add(0,1,1,1,0,0, 0,64'h1020, 1,64'h1000);
        add(0,1,1,1,0,0, 1,64'h1020, 1,64'h1008);
        add(0,1,1,1,0,0, 1,64'h1028, 1,64'h1010);
        add(0,1,1,1,0,0, 1,64'h1030, 1,64'h1018);
        add(0,1,1,1,0,0, 1,64'h1038, 1,64'h1020);
        add(0,1,1,1,0,0, 1,64'h1040, 1,64'h1028);
        // S3: flush with two outstanding (latency 3), misaligned target
        add(1,3,1,1,0,0, 0,64'h1000, 0,0);
        add(0,3,1,1,0,0, 1,64'h1000, 0,0);
        add(0,3,1,1,0,0, 1,64'h1008, 0,0);
        add(0,3,1,1,1,64'h8000_0004, 0,64'h1010, 0,0);
        add(0,3,1,1,0,0, 0,64'h8000_0000, 0,0);
        add(0,3,1,1,0,0, 1,64'h8000_0000, 0,0);
        add(0,3,1,1,0,0, 1,64'h8000_0008, 0,0);
        add(0,3,1,1,0,0, 0,64'h8000_0010, 0,0);
        add(0,3,1,1,0,0, 0,64'h8000_0010, 0,0);
        add(0,3,1,1,0,0, 1,64'h8000_0010, 1,64'h8000_0000);
        add(0,3,1,1,0,0, 1,64'h8000_0018, 1,64'h8000_0008);
        // S4: flush coincides with a response (latency 2): one more dropped
        add(1,2,1,1,0,0, 0,64'h1000, 0,0);
        add(0,2,1,1,0,0, 1,64'h1000, 0,0);
        add(0,2,1,1,0,0, 1,64'h1008, 0,0);
        add(0,2,1,1,1,64'h2000, 0,64'h1010, 0,0);
        add(0,2,1,1,0,0, 1,64'h2000, 0,0);
        add(0,2,1,1,0,0, 1,64'h2008, 0,0);
        add(0,2,1,1,0,0, 0,64'h2010, 0,0);
        add(0,2,1,1,0,0, 1,64'h2010, 1,64'h2000);
        add(0,2,1,1,0,0, 1,64'h2018, 1,64'h2008);
        // S5: grant withheld three cycles; request and address hold
        add(1,1,1,0,0,0, 0,64'h1000, 0,0);
        add(0,1,1,0,0,0, 1,64'h1000, 0,0);
        add(0,1,1,0,0,0, 1,64'h1000, 0,0);
        add(0,1,1,0,0,0, 1,64'h1000, 0,0);
        add(0,1,1,1,0,0, 1,64'h1000, 0,0);
        add(0,1,1,1,0,0, 1,64'h1008, 0,0);
        add(0,1,1,1,0,0, 1,64'h1010, 1,64'h1000);
        add(0,1,1,1,0,0, 1,64'h1018, 1,64'h1008);

        foreach (vecs[i]) begin
            if (vecs[i].start) begin
                lat = vecs[i].lat;
                do_reset();
            end
            fready = vecs[i].rdy; gnt = vecs[i].g;
            flush = vecs[i].fl;   flush_addr = vecs[i].fa;
            @(negedge clk);
            chk($sformatf("row%0d req", i), 64'(req), 64'(vecs[i].ereq));
            chk($sformatf("row%0d address", i), address, vecs[i].eaddr);
            chk($sformatf("row%0d valid", i), 64'(fvalid), 64'(vecs[i].evld));
            if (vecs[i].evld) begin
                chk($sformatf("row%0d fetch_addr", i), faddr, vecs[i].efaddr);
                chk($sformatf("row%0d fetch_rdata", i), frdata, mem_word(vecs[i].efaddr));
            end
            adv();
        end

        // S6: reset while three entries buffered and one response owed
        lat = 1;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            fready = 1'b0; gnt = 1'b1; flush = 1'b0; flush_addr = '0;
            @(negedge clk);
            adv();
        end
        @(negedge clk);
        chk("pre-reset valid", 64'(fvalid), 64'd1);
        chk("pre-reset address", address, 64'h1020);
        rst_ni = 1'b0;
        rvalid = 1'b0;
        #1;
        chk("mid-reset valid", 64'(fvalid), 64'd0);
        chk("mid-reset address", address, 64'h1000);
        chk("mid-reset req", 64'(req), 64'd0);
        do_reset();
        fready = 1'b1; gnt = 1'b1;
        @(negedge clk);
        adv();
        @(negedge clk);
        chk("post-reset req", 64'(req), 64'd1);
        chk("post-reset address", address, 64'h1000);
        adv();
        @(negedge clk);
        adv();
        @(negedge clk);
        chk("post-reset valid", 64'(fvalid), 64'd1);
        chk("post-reset fetch_addr", faddr, 64'h1000);
        chk("post-reset fetch_rdata", frdata, mem_word(64'h1000));
        adv();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
